// File: rtl/mnist_inference_sequencer_if.sv
// Stream bundle between the image loader (x), first dense layer (y) and the
// classifier result channel (class).
//  x_*     : pixel words from image loader (valid/data in, ready out)
//  y_*     : pixel words to layer 1 (valid/data out, ready in)
//  class_* : argmax result beat from classifier (valid/data in, ready out)
// master = sequencer side, slave = surrounding datapath side.
interface mnist_inference_sequencer_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLASS_W = 4
);
  logic [DATA_W-1:0]  x_tdata;
  logic               x_tvalid;
  logic               x_tready;
  logic [DATA_W-1:0]  y_tdata;
  logic               y_tvalid;
  logic               y_tready;
  logic [CLASS_W-1:0] class_tdata;
  logic               class_tvalid;
  logic               class_tready;

  modport master (
    input  x_tdata, x_tvalid,
    output x_tready,
    output y_tdata, y_tvalid,
    input  y_tready,
    input  class_tdata, class_tvalid,
    output class_tready
  );

  modport slave (
    output x_tdata, x_tvalid,
    input  x_tready,
    input  y_tdata, y_tvalid,
    output y_tready,
    output class_tdata, class_tvalid,
    input  class_tready
  );
endinterface

// File: rtl/mnist_inference_sequencer.sv
// Sequences one inference pass: pulses the loader start, forwards exactly
// N_WORDS pixel words loader->layer 1, then waits for the classifier result.
// Ports:
//  s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//  run                      : inference request (level, honoured in IDLE/ERR)
//  loader_start             : one-cycle start pulse to the image loader
//  bus (master)             : x/y pixel streams and class result channel
//  busy, done, timeout_err  : status to the PS register block
//  result                   : last captured class
//  word_count, image_count  : beats this pass / completed inferences
module mnist_inference_sequencer #(
  parameter int unsigned N_WORDS     = 196,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CLASS_W     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_areset,
  input  logic                        run,
  output logic                        loader_start,
  mnist_inference_sequencer_if.master bus,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err,
  output logic [CLASS_W-1:0]          result,
  output logic [CNT_W-1:0]            word_count,
  output logic [15:0]                 image_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);
  // Expiry fires on the idle cycle that would bring the counter to TIMEOUT_CYC-1.
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT_RES,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] tmr;
  logic             start_pass;
  logic             beat;
  logic             res_hs;
  logic             abort;
  logic             tmr_run;

  // State register
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stream gating and status decode
  always_comb begin
    state_next       = state;
    loader_start     = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    bus.x_tready     = 1'b0;
    bus.y_tvalid     = 1'b0;
    bus.y_tdata      = {DATA_W{1'b0}};
    bus.class_tready = 1'b0;
    start_pass       = 1'b0;
    beat             = 1'b0;
    res_hs           = 1'b0;
    abort            = 1'b0;
    tmr_run          = 1'b0;

    case (state)
      S_IDLE, S_ERR: begin
        if (run) begin
          start_pass = 1'b1;
          state_next = S_START;
        end
      end

      S_START: begin
        loader_start = 1'b1;
        busy         = 1'b1;
        state_next   = S_STREAM;
      end

      S_STREAM: begin
        busy         = 1'b1;
        tmr_run      = 1'b1;
        bus.y_tdata  = bus.x_tdata;
        bus.y_tvalid = bus.x_tvalid;
        bus.x_tready = bus.y_tready;
        beat         = bus.x_tvalid && bus.y_tready;
        // A handshake always beats a coincident timeout expiry.
        if (beat) begin
          if (word_count == LAST_WORD) begin
            state_next = S_WAIT_RES;
          end
        end else if (tmr == TMR_LAST) begin
          abort      = 1'b1;
          state_next = S_ERR;
        end
      end

      S_WAIT_RES: begin
        busy             = 1'b1;
        tmr_run          = 1'b1;
        bus.class_tready = 1'b1;
        res_hs           = bus.class_tvalid;
        if (res_hs) begin
          state_next = S_DONE;
        end else if (tmr == TMR_LAST) begin
          abort      = 1'b1;
          state_next = S_ERR;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Pass counters, sticky error, captured result and idle timer
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      word_count  <= '0;
      image_count <= '0;
      timeout_err <= 1'b0;
      result      <= '0;
      tmr         <= '0;
    end else begin
      if (start_pass) begin
        word_count  <= '0;
        timeout_err <= 1'b0;
      end else if (beat) begin
        word_count <= word_count + CNT_W'(1);
      end

      if (abort) begin
        timeout_err <= 1'b1;
      end

      // Count lands together with the done pulse so software sees both at once.
      if (res_hs) begin
        result      <= bus.class_tdata;
        image_count <= image_count + 16'd1;
      end

      if (start_pass || beat || res_hs) begin
        tmr <= '0;
      end else if (tmr_run) begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mnist_inference_sequencer.sv
// Directed bench for mnist_inference_sequencer: basic pass, backpressure,
// overrun, timeout and recovery, ignored run / expiry-cycle beat, mid-pass reset.
module tb_mnist_inference_sequencer;

  localparam int unsigned N_WORDS = 196;
  localparam int unsigned TMO     = 64;

  logic        clk;
  logic        rst;
  logic        run;
  logic        loader_start;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [3:0]  result;
  logic [7:0]  word_count;
  logic [15:0] image_count;

  int          total;
  int          bad;
  int          beats;
  int          word_idx;
  logic [31:0] base;

  mnist_inference_sequencer_if #(.DATA_W(32), .CLASS_W(4)) bus ();

  mnist_inference_sequencer #(
    .N_WORDS    (N_WORDS),
    .DATA_W     (32),
    .CLASS_W    (4),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (8)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .run         (run),
    .loader_start(loader_start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .result      (result),
    .word_count  (word_count),
    .image_count (image_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue run from IDLE/ERR, check the START cycle, leave the DUT in STREAM.
  task automatic begin_pass(input logic [31:0] b, input logic hold);
    base     = b;
    beats    = 0;
    word_idx = 0;
    run      = 1'b1;
    #1;
    chk("pre_loader_start", 32'(loader_start), 0);
    chk("pre_busy", 32'(busy), 0);
    tick();
    if (!hold) run = 1'b0;
    bus.x_tvalid = 1'b1;
    bus.y_tready = 1'b1;
    #1;
    chk("start_loader_start", 32'(loader_start), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_word_count", 32'(word_count), 0);
    chk("start_timeout_err", 32'(timeout_err), 0);
    chk("start_x_tready", 32'(bus.x_tready), 0);
    chk("start_y_tvalid", 32'(bus.y_tvalid), 0);
    bus.x_tvalid = 1'b0;
    tick();
  endtask

  // Drive the loader until the model has seen `target` beats.
  task automatic stream(input int target, input int vpct, input int rpct);
    int cyc;
    cyc = 0;
    while (beats < target && cyc < 3000) begin
      bus.x_tvalid = ($urandom_range(99) < vpct);
      bus.x_tdata  = base + 32'(word_idx);
      bus.y_tready = ($urandom_range(99) < rpct);
      #1;
      chk("x_tready_follow", 32'(bus.x_tready), 32'(bus.y_tready));
      chk("y_tvalid_follow", 32'(bus.y_tvalid), 32'(bus.x_tvalid));
      chk("stream_loader_start", 32'(loader_start), 0);
      if (bus.x_tvalid && bus.y_tready) begin
        chk("y_tdata", bus.y_tdata, base + 32'(word_idx));
        beats++;
        word_idx++;
      end
      tick();
      cyc++;
    end
    chk("beat_total", 32'(beats), 32'(target));
    bus.x_tvalid = 1'b0;
    bus.y_tready = 1'b0;
  endtask

  // Deliver the classifier beat from WAIT_RES and check DONE and return to IDLE.
  task automatic finish_pass(input logic [3:0] cls, input int img);
    #1;
    chk("wait_word_count", 32'(word_count), N_WORDS);
    chk("wait_busy", 32'(busy), 1);
    bus.class_tdata  = cls;
    bus.class_tvalid = 1'b1;
    #1;
    chk("class_tready", 32'(bus.class_tready), 1);
    tick();
    chk("done_pulse", 32'(done), 1);
    chk("done_result", 32'(result), 32'(cls));
    chk("done_busy", 32'(busy), 0);
    chk("done_image_count", 32'(image_count), 32'(img));
    bus.class_tvalid = 1'b0;
    tick();
    chk("idle_done", 32'(done), 0);
    chk("idle_image_count", 32'(image_count), 32'(img));
    chk("idle_result", 32'(result), 32'(cls));
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b1;
    run              = 1'b0;
    bus.x_tdata      = '0;
    bus.x_tvalid     = 1'b0;
    bus.y_tready     = 1'b0;
    bus.class_tdata  = '0;
    bus.class_tvalid = 1'b0;
    base             = '0;
    beats            = 0;
    word_idx         = 0;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loader_start", 32'(loader_start), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_image_count", 32'(image_count), 0);
    rst = 1'b0;
    tick();

    // T1 basic pass, full throughput
    begin_pass(32'h0000_0000, 1'b0);
    stream(N_WORDS, 100, 100);
    finish_pass(4'd7, 1);

    // T2 random valid and backpressure
    begin_pass(32'hA500_0000, 1'b0);
    stream(N_WORDS, 70, 50);
    finish_pass(4'd3, 2);

    // T3 loader keeps offering past the last word
    begin_pass(32'h1234_0000, 1'b0);
    stream(N_WORDS, 100, 100);
    for (int i = 0; i < 4; i++) begin
      bus.x_tvalid = 1'b1;
      bus.x_tdata  = base + 32'(N_WORDS + i);
      bus.y_tready = 1'b1;
      #1;
      chk("overrun_x_tready", 32'(bus.x_tready), 0);
      chk("overrun_y_tvalid", 32'(bus.y_tvalid), 0);
      tick();
    end
    bus.x_tvalid = 1'b0;
    finish_pass(4'd9, 3);

    // T4 stall after 10 beats -> ERR on the 63rd idle cycle, then recover
    begin_pass(32'h0BAD_0000, 1'b0);
    stream(10, 100, 100);
    bus.y_tready = 1'b1;
    repeat (62) tick();
    chk("tmo_pre_busy", 32'(busy), 1);
    chk("tmo_pre_err", 32'(timeout_err), 0);
    tick();
    chk("tmo_busy", 32'(busy), 0);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_word_count", 32'(word_count), 10);
    chk("tmo_result_held", 32'(result), 9);
    tick();
    chk("err_sticky", 32'(timeout_err), 1);
    chk("err_x_tready", 32'(bus.x_tready), 0);
    bus.y_tready = 1'b0;
    begin_pass(32'h5000_0000, 1'b0);
    stream(N_WORDS, 100, 100);
    finish_pass(4'd4, 4);

    // T5 run held through STREAM; beat lands on the exact expiry cycle
    begin_pass(32'h7700_0000, 1'b1);
    stream(20, 100, 100);
    bus.y_tready = 1'b1;
    repeat (62) tick();
    bus.x_tvalid = 1'b1;
    bus.x_tdata  = base + 32'(word_idx);
    #1;
    chk("edge_y_tvalid", 32'(bus.y_tvalid), 1);
    chk("edge_y_tdata", bus.y_tdata, base + 32'(word_idx));
    tick();
    beats++;
    word_idx++;
    bus.x_tvalid = 1'b0;
    chk("edge_busy", 32'(busy), 1);
    chk("edge_err", 32'(timeout_err), 0);
    chk("edge_word_count", 32'(word_count), 21);
    stream(N_WORDS, 80, 70);
    run = 1'b0;
    finish_pass(4'd5, 5);

    // T6 reset at beat 100, then a fresh pass
    begin_pass(32'hC0DE_0000, 1'b0);
    stream(100, 100, 100);
    rst          = 1'b1;
    bus.x_tvalid = 1'b1;
    bus.x_tdata  = 32'hFFFF_FFFF;
    bus.y_tready = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_word_count", 32'(word_count), 0);
    chk("mid_rst_image_count", 32'(image_count), 0);
    chk("mid_rst_result", 32'(result), 0);
    chk("mid_rst_x_tready", 32'(bus.x_tready), 0);
    chk("mid_rst_y_tvalid", 32'(bus.y_tvalid), 0);
    chk("mid_rst_y_tdata", bus.y_tdata, 0);
    chk("mid_rst_class_tready", 32'(bus.class_tready), 0);
    rst          = 1'b0;
    bus.x_tvalid = 1'b0;
    bus.y_tready = 1'b0;
    tick();
    begin_pass(32'h6600_0000, 1'b0);
    stream(N_WORDS, 80, 80);
    finish_pass(4'd2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
